// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the rPLL / downstream reset consumers.
// The sequencer takes the master side; the surrounding fabric (or a bench) takes the slave side.
interface pll_reset_sequencer_if;
    logic       pll_lock;
    logic       pll_reset;
    logic       ram_rst_n;
    logic       logic_rst_n;
    logic       ready;
    logic       fault;
    logic [2:0] retry_count;
    logic [2:0] state;

    modport master (
        input  pll_lock,
        output pll_reset,
        output ram_rst_n,
        output logic_rst_n,
        output ready,
        output fault,
        output retry_count,
        output state
    );

    modport slave (
        output pll_lock,
        input  pll_reset,
        input  ram_rst_n,
        input  logic_rst_n,
        input  ready,
        input  fault,
        input  retry_count,
        input  state
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Brings up the rPLL from the free-running board clock, debounces LOCK, then releases the
// RAM controller and core-logic resets in order; lock loss restarts, repeated timeouts fault.
module pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES = 27,
    parameter int unsigned LOCK_TIMEOUT   = 27000,
    parameter int unsigned LOCK_STABLE    = 2700,
    parameter int unsigned STAGE_GAP      = 16,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pll_reset_sequencer_if.master bus
);

    localparam int unsigned MAX_A  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES
                                                                     : LOCK_TIMEOUT;
    localparam int unsigned MAX_B  = (LOCK_STABLE > STAGE_GAP) ? LOCK_STABLE : STAGE_GAP;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        StPllRst   = 3'd0,
        StWaitLock = 3'd1,
        StFilter   = 3'd2,
        StRelRam   = 3'd3,
        StRelLogic = 3'd4,
        StRun      = 3'd5,
        StFault    = 3'd6
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             retry_q, retry_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;

    logic pll_reset_d, ram_rst_n_d, logic_rst_n_d, ready_d, fault_d;

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_q;

        case (state_q)
            StPllRst: begin
                if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) state_d = StWaitLock;
            end
            StWaitLock: begin
                // A lock arriving on the timeout cycle still counts as a lock.
                if (lock_s) begin
                    state_d = StFilter;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    if (retry_q == 3'(MAX_RETRIES)) begin
                        state_d = StFault;
                    end else begin
                        retry_d = retry_q + 3'd1;
                        state_d = StPllRst;
                    end
                end
            end
            StFilter: begin
                if (!lock_s) begin
                    state_d = StWaitLock;
                end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
                    state_d = StRelRam;
                end
            end
            StRelRam: begin
                if (!lock_s) begin
                    state_d = StPllRst;
                end else if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
                    state_d = StRelLogic;
                end
            end
            StRelLogic: begin
                if (!lock_s) begin
                    state_d = StPllRst;
                end else if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                cnt_d = cnt_q;
                if (!lock_s) state_d = StPllRst;
            end
            StFault: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = StPllRst;
            end
        endcase

        if (state_d != state_q) cnt_d = '0;
        if (state_d == StRun) retry_d = '0;

        // Outputs are decoded from the next state so they register alongside it.
        pll_reset_d   = (state_d == StPllRst) || (state_d == StFault);
        ram_rst_n_d   = (state_d == StRelRam) || (state_d == StRelLogic) || (state_d == StRun);
        logic_rst_n_d = (state_d == StRelLogic) || (state_d == StRun);
        ready_d       = (state_d == StRun);
        fault_d       = (state_d == StFault);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= StPllRst;
            cnt_q           <= '0;
            retry_q         <= '0;
            sync_q          <= '0;
            bus.pll_reset   <= 1'b1;
            bus.ram_rst_n   <= 1'b0;
            bus.logic_rst_n <= 1'b0;
            bus.ready       <= 1'b0;
            bus.fault       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            retry_q         <= retry_d;
            sync_q          <= {sync_q[SYNC_STAGES-2:0], bus.pll_lock};
            bus.pll_reset   <= pll_reset_d;
            bus.ram_rst_n   <= ram_rst_n_d;
            bus.logic_rst_n <= logic_rst_n_d;
            bus.ready       <= ready_d;
            bus.fault       <= fault_d;
        end
    end

    assign bus.retry_count = retry_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer using the small test parameter set.
module tb_pll_reset_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    pll_reset_sequencer_if bus ();

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (20),
        .LOCK_STABLE   (8),
        .STAGE_GAP     (3),
        .MAX_RETRIES   (2),
        .SYNC_STAGES   (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the sample point right after the last reset edge, rst_n released.
    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.pll_lock = 1'b0;
        do_reset();
        checks++;
        if ({bus.pll_reset, bus.ram_rst_n, bus.logic_rst_n, bus.ready, bus.fault} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=10000",
                     {bus.pll_reset, bus.ram_rst_n, bus.logic_rst_n, bus.ready, bus.fault});
        end
        checks++;
        if (bus.retry_count !== 3'd0) begin
            failures++;
            $display("FAIL reset_retry got=%0d exp=0", bus.retry_count);
        end
        checks++;
        if (bus.state !== 3'd0) begin
            failures++;
            $display("FAIL reset_state got=%0d exp=0", bus.state);
        end
    endtask

    task automatic test_normal();
        int n;
        bus.pll_lock = 1'b0;
        do_reset();
        n = 0;
        while (bus.pll_reset === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL normal_pll_reset_width got=%0d exp=4", n);
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (bus.state !== 3'd1 || bus.ram_rst_n !== 1'b0) begin
            failures++;
            $display("FAIL normal_waiting state=%0d ram=%b exp state=1 ram=0", bus.state, bus.ram_rst_n);
        end
        bus.pll_lock = 1'b1;
        n = 0;
        while (bus.state !== 3'd2 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL normal_lock_to_filter got=%0d exp=3", n);
        end
        n = 0;
        while (bus.ram_rst_n !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != 8 || bus.logic_rst_n !== 1'b0 || bus.state !== 3'd3) begin
            failures++;
            $display("FAIL normal_ram_release cycles=%0d logic=%b state=%0d exp 8/0/3",
                     n, bus.logic_rst_n, bus.state);
        end
        n = 0;
        while (bus.logic_rst_n !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 3 || bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL normal_logic_release cycles=%0d ready=%b exp 3/0", n, bus.ready);
        end
        n = 0;
        while (bus.ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL normal_ready cycles=%0d exp=3", n);
        end
        checks++;
        if ({bus.state, bus.retry_count, bus.pll_reset, bus.ram_rst_n, bus.logic_rst_n} !== 9'b101_000_011) begin
            failures++;
            $display("FAIL normal_run state=%0d retry=%0d pr=%b ram=%b logic=%b exp 5/0/0/1/1",
                     bus.state, bus.retry_count, bus.pll_reset, bus.ram_rst_n, bus.logic_rst_n);
        end
    endtask

    // Entered from RUN with lock high; one-cycle dropout must restart the full bring-up.
    task automatic test_run_loss();
        int exp_st;
        bus.pll_lock = 1'b0;
        for (int i = 1; i <= 22; i++) begin
            tick();
            if (i == 1) bus.pll_lock = 1'b1;
            if (i <= 2)       exp_st = 5;
            else if (i <= 6)  exp_st = 0;
            else if (i == 7)  exp_st = 1;
            else if (i <= 15) exp_st = 2;
            else if (i <= 18) exp_st = 3;
            else if (i <= 21) exp_st = 4;
            else              exp_st = 5;
            checks++;
            if (int'(bus.state) != exp_st) begin
                failures++;
                $display("FAIL loss_state tick=%0d got=%0d exp=%0d", i, bus.state, exp_st);
            end
            if (i == 3) begin
                checks++;
                if ({bus.pll_reset, bus.ram_rst_n, bus.logic_rst_n, bus.ready} !== 4'b1000) begin
                    failures++;
                    $display("FAIL loss_outputs got=%b exp=1000",
                             {bus.pll_reset, bus.ram_rst_n, bus.logic_rst_n, bus.ready});
                end
            end
        end
        checks++;
        if (bus.ready !== 1'b1 || bus.retry_count !== 3'd0) begin
            failures++;
            $display("FAIL loss_rerun ready=%b retry=%0d exp 1/0", bus.ready, bus.retry_count);
        end
    endtask

    task automatic test_glitch();
        int n;
        int exp_st;
        bus.pll_lock = 1'b0;
        do_reset();
        n = 0;
        while (bus.pll_reset === 1'b1 && n < 50) begin
            tick();
            n++;
        end
        bus.pll_lock = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (i == 5) bus.pll_lock = 1'b0;
            if (i == 7) bus.pll_lock = 1'b1;
            if (i <= 2)       exp_st = 1;
            else if (i <= 7)  exp_st = 2;
            else if (i <= 9)  exp_st = 1;
            else if (i <= 17) exp_st = 2;
            else              exp_st = 3;
            checks++;
            if (int'(bus.state) != exp_st || bus.ram_rst_n !== (i >= 18) ||
                bus.retry_count !== 3'd0) begin
                failures++;
                $display("FAIL glitch tick=%0d state=%0d ram=%b retry=%0d exp state=%0d ram=%b retry=0",
                         i, bus.state, bus.ram_rst_n, bus.retry_count, exp_st, (i >= 18));
            end
        end
    endtask

    task automatic test_timeout();
        logic       exp_pr;
        logic       exp_fault;
        logic [2:0] exp_retry;
        bus.pll_lock = 1'b0;
        do_reset();
        for (int t = 0; t <= 75; t++) begin
            exp_pr    = (t < 4) || (t >= 24 && t < 28) || (t >= 48 && t < 52) || (t >= 72);
            exp_retry = (t < 24) ? 3'd0 : ((t < 48) ? 3'd1 : 3'd2);
            exp_fault = (t >= 72);
            checks++;
            if ({bus.pll_reset, bus.fault, bus.retry_count} !== {exp_pr, exp_fault, exp_retry}) begin
                failures++;
                $display("FAIL timeout t=%0d pr=%b fault=%b retry=%0d exp pr=%b fault=%b retry=%0d",
                         t, bus.pll_reset, bus.fault, bus.retry_count, exp_pr, exp_fault, exp_retry);
            end
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            bus.pll_lock = (i % 4) >= 2;
            tick();
            checks++;
            if ({bus.state, bus.pll_reset, bus.fault, bus.ram_rst_n, bus.ready} !== 7'b110_1100) begin
                failures++;
                $display("FAIL fault_sticky i=%0d state=%0d pr=%b fault=%b ram=%b ready=%b",
                         i, bus.state, bus.pll_reset, bus.fault, bus.ram_rst_n, bus.ready);
            end
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (bus.fault !== 1'b0 || bus.state !== 3'd0 || bus.retry_count !== 3'd0) begin
            failures++;
            $display("FAIL fault_clear fault=%b state=%0d retry=%0d exp 0/0/0",
                     bus.fault, bus.state, bus.retry_count);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_recover();
        bus.pll_lock = 1'b0;
        do_reset();
        for (int t = 0; t <= 47; t++) begin
            if (t == 29) begin
                checks++;
                if (bus.retry_count !== 3'd1 || bus.state !== 3'd1) begin
                    failures++;
                    $display("FAIL recover_retry1 retry=%0d state=%0d exp 1/1", bus.retry_count, bus.state);
                end
            end
            if (t == 30) bus.pll_lock = 1'b1;
            if (t == 46) begin
                checks++;
                if (bus.retry_count !== 3'd1 || bus.state !== 3'd4) begin
                    failures++;
                    $display("FAIL recover_pre_run retry=%0d state=%0d exp 1/4", bus.retry_count, bus.state);
                end
            end
            if (t == 47) begin
                checks++;
                if (bus.retry_count !== 3'd0 || bus.state !== 3'd5 || bus.ready !== 1'b1) begin
                    failures++;
                    $display("FAIL recover_run retry=%0d state=%0d ready=%b exp 0/5/1",
                             bus.retry_count, bus.state, bus.ready);
                end
            end
            if (t < 47) tick();
        end
    endtask

    task automatic test_reset_mid();
        bus.pll_lock = 1'b0;
        do_reset();
        bus.pll_lock = 1'b1;
        for (int t = 0; t < 17; t++) tick();
        checks++;
        if (bus.state !== 3'd4 || bus.ram_rst_n !== 1'b1 || bus.logic_rst_n !== 1'b1) begin
            failures++;
            $display("FAIL mid_rel_logic state=%0d ram=%b logic=%b exp 4/1/1",
                     bus.state, bus.ram_rst_n, bus.logic_rst_n);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({bus.pll_reset, bus.ram_rst_n, bus.logic_rst_n, bus.ready, bus.fault,
             bus.retry_count, bus.state} !== 11'b10000_000_000) begin
            failures++;
            $display("FAIL mid_reset pr=%b ram=%b logic=%b ready=%b fault=%b retry=%0d state=%0d",
                     bus.pll_reset, bus.ram_rst_n, bus.logic_rst_n, bus.ready, bus.fault,
                     bus.retry_count, bus.state);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.pll_lock = 1'b0;
        test_reset();
        test_normal();
        test_run_loss();
        test_glitch();
        test_timeout();
        test_recover();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
